rf_frame_serializer: RTL and testbench

Frame builder upstream of the Manchester encoder in the RF transmit path. Accepts a transmit request and a stream of payload bytes. Emits preamble, sync word, length byte and payload as an NRZ bit stream on `din_out`, one bit per two `clk2x` cycles, aligned to the encoder's two-phase sampling. It also drives the encoder's `enable` and reports completion or payload underrun.

---
 rtl/rf_frame_serializer.sv | 184 ++++++++++++++++++
 tb/tb_rf_frame_serializer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rf_frame_serializer.sv
// rf_frame_serializer: builds preamble / sync / length / payload frames and
// shifts them out NRZ, one bit per two clk2x cycles, aligned to the
// Manchester encoder's two-phase sampling (bits change only on ph==1 edges).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for tx_start (length captured into byte_cnt on accept)
// ARM   | request accepted, waiting for the ph==1 edge to emit bit 0
// PRE   | din_out holds a preamble bit (alternating, starting with 1)
// SYNC  | din_out holds a sync word bit, MSB first
// LEN   | din_out holds a length byte bit, MSB first
// PAY   | din_out holds a payload bit, MSB first
// FIN   | frame end; collapsed onto the exit edge, never registered
//
// bit_cnt is a down-counter of bits still to follow in the current field;
// the ph==1 edge with bit_cnt==0 ends the field. byte_cnt holds the length
// during LEN and then the number of payload bytes still to fetch.
module rf_frame_serializer #(
  parameter int          PREAMBLE_BITS = 16,
  parameter int          SYNC_BITS     = 16,
  parameter logic [31:0] SYNC_WORD     = 32'h0000_D391
) (
  input  logic       clk2x,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_len,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       din_out,
  output logic       enc_enable,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int             SB        = SYNC_BITS;
  localparam logic [SB-1:0]  SW        = SYNC_WORD[SB-1:0];
  localparam logic [5:0]     PRE_LAST  = 6'(PREAMBLE_BITS - 1);
  localparam logic [5:0]     SYNC_LAST = 6'(SYNC_BITS - 1);

  typedef enum logic [2:0] {IDLE, ARM, PRE, SYNC, LEN, PAY, FIN} state_t;

  state_t        state, state_nxt;
  logic          ph;
  logic [5:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    byte_cnt, byte_cnt_nxt;
  logic [SB-1:0] sh, sh_nxt;
  logic          din_nxt, en_nxt, busy_nxt, done_nxt, underrun_nxt;
  logic          field_end;

  assign field_end = (bit_cnt == 6'd0);

  // State, phase and datapath registers; ph free-runs from reset release.
  always_ff @(posedge clk2x or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ph         <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      sh         <= '0;
      din_out    <= 1'b0;
      enc_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      ph         <= ~ph;
      bit_cnt    <= bit_cnt_nxt;
      byte_cnt   <= byte_cnt_nxt;
      sh         <= sh_nxt;
      din_out    <= din_nxt;
      enc_enable <= en_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      underrun   <= underrun_nxt;
    end
  end

  // Next-state, bit sequencing, byte fetch and frame termination.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    sh_nxt       = sh;
    din_nxt      = din_out;
    en_nxt       = enc_enable;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    underrun_nxt = 1'b0;
    byte_ready   = 1'b0;

    case (state)
      IDLE: begin
        if (tx_start) begin
          state_nxt    = ARM;
          byte_cnt_nxt = tx_len;
          busy_nxt     = 1'b1;
        end
      end

      ARM: begin
        if (ph) begin
          state_nxt   = PRE;
          din_nxt     = 1'b1;
          en_nxt      = 1'b1;
          bit_cnt_nxt = PRE_LAST;
        end
      end

      PRE: begin
        if (ph) begin
          if (field_end) begin
            state_nxt   = SYNC;
            din_nxt     = SW[SB-1];
            sh_nxt      = SW << 1;
            bit_cnt_nxt = SYNC_LAST;
          end else begin
            din_nxt     = ~din_out;
            bit_cnt_nxt = bit_cnt - 6'd1;
          end
        end
      end

      SYNC: begin
        if (ph) begin
          if (field_end) begin
            state_nxt          = LEN;
            din_nxt            = byte_cnt[7];
            sh_nxt             = '0;
            sh_nxt[SB-1 -: 8]  = {byte_cnt[6:0], 1'b0};
            bit_cnt_nxt        = 6'd7;
          end else begin
            din_nxt     = sh[SB-1];
            sh_nxt      = sh << 1;
            bit_cnt_nxt = bit_cnt - 6'd1;
          end
        end
      end

      LEN, PAY: begin
        // A byte is needed at the end of LEN and of every byte but the last.
        byte_ready = field_end && (byte_cnt != 8'd0);
        if (ph) begin
          if (field_end) begin
            if (byte_cnt == 8'd0) begin
              state_nxt = IDLE;
              din_nxt   = 1'b0;
              en_nxt    = 1'b0;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else if (byte_valid) begin
              state_nxt          = PAY;
              din_nxt            = byte_data[7];
              sh_nxt             = '0;
              sh_nxt[SB-1 -: 8]  = {byte_data[6:0], 1'b0};
              bit_cnt_nxt        = 6'd7;
              byte_cnt_nxt       = byte_cnt - 8'd1;
            end else begin
              state_nxt    = IDLE;
              din_nxt      = 1'b0;
              en_nxt       = 1'b0;
              busy_nxt     = 1'b0;
              underrun_nxt = 1'b1;
            end
          end else begin
            din_nxt     = sh[SB-1];
            sh_nxt      = sh << 1;
            bit_cnt_nxt = bit_cnt - 6'd1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        din_nxt   = 1'b0;
        en_nxt    = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rf_frame_serializer.sv
// Testbench for rf_frame_serializer: directed and randomized frames checked
// against a bit-list model built from the frame format.
module tb_rf_frame_serializer;

  localparam int          P  = 16;
  localparam int          S  = 16;
  localparam logic [15:0] SW = 16'hD391;

  logic       clk2x = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_len;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready, din_out, enc_enable, busy, done, underrun;

  int checks = 0;
  int failures = 0;
  int edges;
  logic [7:0] pay [0:15];

  rf_frame_serializer dut (
    .clk2x(clk2x), .rst(rst), .tx_start(tx_start), .tx_len(tx_len),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .din_out(din_out), .enc_enable(enc_enable), .busy(busy), .done(done),
    .underrun(underrun)
  );

  always #5 clk2x = ~clk2x;

  // Edges since reset release; the phase seen at the next edge is edges%2.
  always @(posedge clk2x or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_din"},      32'(din_out),    0);
    chk({tag, "_enable"},   32'(enc_enable), 0);
    chk({tag, "_busy"},     32'(busy),       0);
    chk({tag, "_done"},     32'(done),       0);
    chk({tag, "_underrun"}, 32'(underrun),   0);
    chk({tag, "_ready"},    32'(byte_ready), 0);
  endtask

  // Runs one frame. fail_at: index of the byte fetch withheld (-1 none);
  // want_ph: phase of the tx_start edge (-1 any); poke: sample index of a
  // mid-frame tx_start pulse (-1 none); rst_at: sample index of a reset (-1 none).
  task automatic frame(input int len, input int fail_at, input int want_ph,
                       input int poke, input int rst_at);
    bit         exp_bits[$];
    logic [7:0] lb;
    int         lat, k, nbits, b, f, ebr;
    lb = len[7:0];
    for (int i = 0; i < P; i++) exp_bits.push_back(i % 2 == 0);
    for (int i = 0; i < S; i++) exp_bits.push_back(SW[S-1-i]);
    for (int i = 0; i < 8; i++) exp_bits.push_back(lb[7-i]);
    for (int j = 0; j < len; j++)
      for (int i = 0; i < 8; i++) exp_bits.push_back(pay[j][7-i]);

    if (want_ph >= 0 && (edges % 2) != want_ph) @(negedge clk2x);
    lat        = (edges % 2 == 0) ? 1 : 2;
    tx_start   = 1'b1;
    tx_len     = lb;
    byte_data  = pay[0];
    byte_valid = (fail_at != 0);
    @(negedge clk2x);
    tx_start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("done_after_start", 32'(done), 0);

    k = 1;
    while (!enc_enable && k < 6) begin
      @(negedge clk2x);
      k++;
    end
    chk("start_latency", k, lat + 1);
    if (k != lat + 1) return;

    nbits = (fail_at >= 0) ? (P + S + 8 + 8 * fail_at) : exp_bits.size();
    for (int i = 0; i < 2 * nbits; i++) begin
      b   = i / 2;
      ebr = (b >= P + S + 7 && (b - (P + S + 7)) % 8 == 0 && (b - (P + S + 7)) / 8 < len) ? 1 : 0;
      chk($sformatf("enable_bit%0d", b), 32'(enc_enable), 1);
      chk($sformatf("din_bit%0d", b),    32'(din_out),    32'(exp_bits[b]));
      chk($sformatf("ready_bit%0d", b),  32'(byte_ready), ebr);
      chk($sformatf("busy_bit%0d", b),   32'(busy),       1);
      if (i == rst_at) begin
        tx_start = 1'b0;
        #1 rst = 1'b1;
        #1 chk_quiet("async_reset");
        @(negedge clk2x);
        rst        = 1'b0;
        byte_valid = 1'b0;
        return;
      end
      f          = (b <= P + S + 7) ? 0 : (b - (P + S + 8)) / 8 + 1;
      byte_data  = (f < 16) ? pay[f] : 8'h00;
      byte_valid = (f != fail_at);
      tx_start   = (i == poke);
      if (i == poke) tx_len = 8'($urandom_range(0, 255));
      @(negedge clk2x);
    end
    tx_start = 1'b0;

    if (fail_at >= 0) begin
      chk("underrun_pulse",    32'(underrun),   1);
      chk("underrun_enable",   32'(enc_enable), 0);
      chk("underrun_busy",     32'(busy),       0);
      chk("underrun_din",      32'(din_out),    0);
      chk("underrun_no_done",  32'(done),       0);
      byte_valid = 1'b0;
      repeat (3) begin
        @(negedge clk2x);
        chk("after_underrun", 32'(underrun), 0);
        chk("no_done_later",  32'(done),     0);
      end
    end else begin
      chk("done_pulse",    32'(done),       1);
      chk("done_enable",   32'(enc_enable), 0);
      chk("done_busy",     32'(busy),       0);
      chk("done_din",      32'(din_out),    0);
      chk("done_underrun", 32'(underrun),   0);
      chk("done_ready",    32'(byte_ready), 0);
      byte_valid = 1'b0;
    end
  endtask

  initial begin
    int len, fail, wph;
    rst        = 1'b1;
    tx_start   = 1'b0;
    tx_len     = 8'h00;
    byte_data  = 8'h00;
    byte_valid = 1'b0;
    for (int j = 0; j < 16; j++) pay[j] = 8'h00;
    @(negedge clk2x);
    @(negedge clk2x);
    chk_quiet("reset");
    rst = 1'b0;
    @(negedge clk2x);
    chk_quiet("idle");

    // Directed frame, start on a ph==0 edge.
    pay[0] = 8'hA5;
    pay[1] = 8'h3C;
    frame(2, -1, 0, -1, -1);

    // Empty payload, start on a ph==1 edge.
    @(negedge clk2x);
    frame(0, -1, 1, -1, -1);

    // Second byte withheld.
    for (int j = 0; j < 16; j++) pay[j] = 8'($urandom);
    frame(3, 1, -1, -1, -1);

    // Ignored mid-frame request, then back-to-back start right after done.
    len = $urandom_range(1, 4);
    frame(len, -1, -1, 20, -1);
    frame($urandom_range(0, 3), -1, -1, -1, -1);

    // Randomized frames.
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 16; j++) pay[j] = 8'($urandom);
      len  = $urandom_range(0, 6);
      fail = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      wph  = $urandom_range(0, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk2x);
      frame(len, fail, wph, -1, -1);
    end

    // Reset in the middle of the payload, then a clean frame.
    for (int j = 0; j < 16; j++) pay[j] = 8'($urandom);
    frame(4, -1, -1, 2 * (P + S + 8) + 5, -1 + 0 * 0 + 0 - 0 + 2 * (P + S + 8) + 5 - (2 * (P + S + 8) + 5) - 1 == -2 ? -1 : -1);
    repeat (2) @(negedge clk2x);
    frame(4, -1, -1, -1, 2 * (P + S + 8) + 5);
    chk_quiet("post_reset");
    chk("post_reset_phase", edges % 2, 0);
    frame(2, -1, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
